// File: rtl/avalon_mm_csr_slave.sv
// avalon_mm_csr_slave: Avalon-MM responder for the audio-effect CSR bank.
// RW control registers at word addresses 0..NUM_RW-1 are exported on ctrl_o.
// RO status words follow at NUM_RW..NUM_RW+NUM_RO-1. Reads use fixed latency
// with readdatavalid. Waitrequest covers post-reset init and the commit stall.
// Optional feature macro: AVMM_CSR_SHADOW_EN (shadow/commit double buffering;
// the COMMIT register sits at address NUM_RW+NUM_RO).
module avalon_mm_csr_slave #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 16,
    parameter int NUM_RW       = 8,
    parameter int NUM_RO       = 4,
    parameter int READ_LATENCY = 2,
    parameter int INIT_CYCLES  = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [ADDR_WIDTH-1:0]        avs_address_i,
    input  logic                         avs_write_i,
    input  logic [DATA_WIDTH-1:0]        avs_writedata_i,
    input  logic [DATA_WIDTH/8-1:0]      avs_byteenable_i,
    input  logic                         avs_read_i,
    output logic [DATA_WIDTH-1:0]        avs_readdata_o,
    output logic                         avs_readdatavalid_o,
    output logic                         avs_waitrequest_o,
    input  logic [NUM_RW*DATA_WIDTH-1:0] rw_defaults_i,
    input  logic [NUM_RO*DATA_WIDTH-1:0] status_i,
    input  logic                         update_i,
    output logic [NUM_RW*DATA_WIDTH-1:0] ctrl_o
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int CNT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INIT_CYCLES - 1);

`ifdef AVMM_CSR_SHADOW_EN
    localparam logic [ADDR_WIDTH-1:0] COMMIT_ADDR = ADDR_WIDTH'(NUM_RW + NUM_RO);
    typedef enum logic [1:0] {S_INIT, S_READY, S_COMMIT_WAIT} state_t;
`else
    typedef enum logic [1:0] {S_INIT, S_READY} state_t;
`endif

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       init_cnt_q, init_cnt_d;
    logic                   init_load;
    logic                   commit_now;
    logic                   wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0]  rw_q [NUM_RW];
    logic [DATA_WIDTH-1:0]  rd_word;
    logic [READ_LATENCY-1:0] vld_q;
    logic [DATA_WIDTH-1:0]  dat_q [READ_LATENCY];

    // State and init counter registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // Next-state, waitrequest and load/commit strobes
    always_comb begin
        state_d           = state_q;
        init_cnt_d        = init_cnt_q;
        avs_waitrequest_o = 1'b1;
        init_load         = 1'b0;
        commit_now        = 1'b0;
        unique case (state_q)
            S_INIT: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == CNT_LAST) begin
                    init_load  = 1'b1;
                    init_cnt_d = '0;
                    state_d    = S_READY;
                end
            end
            S_READY: begin
                avs_waitrequest_o = 1'b0;
`ifdef AVMM_CSR_SHADOW_EN
                // A COMMIT write without update_i is stalled until the
                // next sample boundary so the effect blocks never see a
                // half-updated parameter set.
                if (avs_write_i && avs_address_i == COMMIT_ADDR) begin
                    if (update_i) begin
                        commit_now = 1'b1;
                    end else begin
                        avs_waitrequest_o = 1'b1;
                        state_d           = S_COMMIT_WAIT;
                    end
                end
`endif
            end
`ifdef AVMM_CSR_SHADOW_EN
            S_COMMIT_WAIT: begin
                if (update_i) begin
                    avs_waitrequest_o = 1'b0;
                    commit_now        = 1'b1;
                    state_d           = S_READY;
                end
            end
`endif
            default: state_d = S_INIT;
        endcase
    end

    // A simultaneous read+write is a protocol violation: the write wins
    assign wr_acc = avs_write_i & ~avs_waitrequest_o;
    assign rd_acc = avs_read_i & ~avs_write_i & ~avs_waitrequest_o;

    // RW (or shadow) registers: init load, then byte-lane writes
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NUM_RW; k++) rw_q[k] <= '0;
        end else if (init_load) begin
            for (int k = 0; k < NUM_RW; k++)
                rw_q[k] <= rw_defaults_i[k*DATA_WIDTH +: DATA_WIDTH];
        end else if (wr_acc) begin
            for (int k = 0; k < NUM_RW; k++) begin
                if (avs_address_i == ADDR_WIDTH'(k)) begin
                    for (int b = 0; b < BE_W; b++) begin
                        if (avs_byteenable_i[b])
                            rw_q[k][b*8 +: 8] <= avs_writedata_i[b*8 +: 8];
                    end
                end
            end
        end
    end

`ifdef AVMM_CSR_SHADOW_EN
    logic [DATA_WIDTH-1:0] commit_q [NUM_RW];

    // Committed copy: loaded at init, copied from shadow on commit
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NUM_RW; k++) commit_q[k] <= '0;
        end else if (init_load) begin
            for (int k = 0; k < NUM_RW; k++)
                commit_q[k] <= rw_defaults_i[k*DATA_WIDTH +: DATA_WIDTH];
        end else if (commit_now) begin
            for (int k = 0; k < NUM_RW; k++) commit_q[k] <= rw_q[k];
        end
    end

    for (genvar g = 0; g < NUM_RW; g++) begin : g_ctrl
        assign ctrl_o[g*DATA_WIDTH +: DATA_WIDTH] = commit_q[g];
    end
`else
    logic unused_update;
    assign unused_update = update_i ^ commit_now;

    for (genvar g = 0; g < NUM_RW; g++) begin : g_ctrl
        assign ctrl_o[g*DATA_WIDTH +: DATA_WIDTH] = rw_q[g];
    end
`endif

    // Read decode; unmapped addresses (including COMMIT) read as zero
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NUM_RW; k++)
            if (avs_address_i == ADDR_WIDTH'(k)) rd_word = rw_q[k];
        for (int j = 0; j < NUM_RO; j++)
            if (avs_address_i == ADDR_WIDTH'(NUM_RW + j))
                rd_word = status_i[j*DATA_WIDTH +: DATA_WIDTH];
    end

    // Read pipeline; data stages only advance with a valid so the last
    // stage holds the previous read data while readdatavalid is low
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= '0;
            for (int k = 0; k < READ_LATENCY; k++) dat_q[k] <= '0;
        end else begin
            vld_q[0] <= rd_acc;
            if (rd_acc) dat_q[0] <= rd_word;
            for (int k = 1; k < READ_LATENCY; k++) begin
                vld_q[k] <= vld_q[k-1];
                if (vld_q[k-1]) dat_q[k] <= dat_q[k-1];
            end
        end
    end

    assign avs_readdatavalid_o = vld_q[READ_LATENCY-1];
    assign avs_readdata_o      = dat_q[READ_LATENCY-1];

endmodule

// File: tb/tb_avalon_mm_csr_slave.sv
// Directed testbench for avalon_mm_csr_slave: init sequence, table of
// single transactions, back-to-back reads, same-address write/read,
// read+write collision, commit stall (with AVMM_CSR_SHADOW_EN), mid-read reset.
module tb_avalon_mm_csr_slave;
    localparam int DW = 16, AW = 16, NRW = 8, NRO = 4, RL = 2, IC = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [AW-1:0]     addr = '0;
    logic              wr = 1'b0, rd = 1'b0;
    logic [DW-1:0]     wdata = '0;
    logic [DW/8-1:0]   be = '0;
    logic [DW-1:0]     rdata;
    logic              rvalid, waitreq;
    logic [NRW*DW-1:0] defaults;
    logic [NRO*DW-1:0] status;
    logic              update = 1'b0;
    logic [NRW*DW-1:0] ctrl;

    int n_vec = 0;
    int n_bad = 0;

    avalon_mm_csr_slave #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RW(NRW), .NUM_RO(NRO),
        .READ_LATENCY(RL), .INIT_CYCLES(IC)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .avs_address_i(addr), .avs_write_i(wr), .avs_writedata_i(wdata),
        .avs_byteenable_i(be), .avs_read_i(rd),
        .avs_readdata_o(rdata), .avs_readdatavalid_o(rvalid),
        .avs_waitrequest_o(waitreq),
        .rw_defaults_i(defaults), .status_i(status), .update_i(update),
        .ctrl_o(ctrl)
    );

    always #5 clk = ~clk;

    // Flag protocol violations the bench itself drives
    always @(posedge clk)
        if (rd && wr) $display("note: read and write both high at %0t (protocol violation)", $time);

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic          is_rd;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [1:0]    b;
        int            chk_reg;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vt [13];
    logic [DW-1:0] def_w [NRW];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after reset release; checks the waitrequest window and load
    task automatic check_init(input string tag);
        check({tag, "_wait0"}, waitreq, 1'b1);
        check({tag, "_ctrl0"}, ctrl, '0);
        for (int i = 1; i < IC; i++) begin
            step();
            check({tag, "_wait"}, waitreq, 1'b1);
            check({tag, "_noval"}, rvalid, 1'b0);
        end
        step();
        check({tag, "_ready"}, waitreq, 1'b0);
        check({tag, "_ctrl_def"}, ctrl, defaults);
        check({tag, "_noval_end"}, rvalid, 1'b0);
    endtask

    task automatic bus_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] b);
        addr = a; wdata = d; be = b; wr = 1'b1;
        step();
        wr = 1'b0;
`ifdef AVMM_CSR_SHADOW_EN
        // Commit immediately so ctrl_o tracks the write
        addr = AW'(NRW + NRO); update = 1'b1; wr = 1'b1;
        step();
        wr = 1'b0; update = 1'b0;
`endif
    endtask

    task automatic bus_rd(input string nm, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        addr = a; rd = 1'b1;
        step();
        rd = 1'b0;
        for (int i = 1; i < RL; i++) begin
            check({nm, "_early"}, rvalid, 1'b0);
            step();
        end
        check({nm, "_valid"}, rvalid, 1'b1);
        check({nm, "_data"}, rdata, exp);
        step();
        check({nm, "_valid_drop"}, rvalid, 1'b0);
        check({nm, "_hold"}, rdata, exp);
    endtask

    initial begin
        def_w = '{16'hA000, 16'h0001, 16'h1234, 16'h3333,
                  16'h4444, 16'h5555, 16'h6666, 16'h7777};
        for (int k = 0; k < NRW; k++) defaults[k*DW +: DW] = def_w[k];
        status = {16'h0044, 16'h0033, 16'h0022, 16'h0011};

        //         rd    addr      wdata     be     reg exp
        vt[0]  = '{1'b0, 16'd2,    16'hABCD, 2'b10, 2, 16'hAB34};
        vt[1]  = '{1'b1, 16'd2,    16'h0000, 2'b00, 0, 16'hAB34};
        vt[2]  = '{1'b0, 16'd0,    16'hBEEF, 2'b11, 0, 16'hBEEF};
        vt[3]  = '{1'b0, 16'd0,    16'h00CC, 2'b01, 0, 16'hBECC};
        vt[4]  = '{1'b1, 16'd0,    16'h0000, 2'b00, 0, 16'hBECC};
        vt[5]  = '{1'b0, 16'd9,    16'hFFFF, 2'b11, 1, 16'h0001};
        vt[6]  = '{1'b1, 16'd9,    16'h0000, 2'b00, 0, 16'h0022};
        vt[7]  = '{1'b0, 16'd13,   16'h5A5A, 2'b11, 7, 16'h7777};
        vt[8]  = '{1'b1, 16'd12,   16'h0000, 2'b00, 0, 16'h0000};
        vt[9]  = '{1'b1, 16'hFFFF, 16'h0000, 2'b00, 0, 16'h0000};
        vt[10] = '{1'b0, 16'd7,    16'h0F0F, 2'b00, 7, 16'h7777};
        vt[11] = '{1'b1, 16'd7,    16'h0000, 2'b00, 0, 16'h7777};
        vt[12] = '{1'b1, 16'd11,   16'h0000, 2'b00, 0, 16'h0044};

        // Reset state
        step();
        step();
        check("rst_wait", waitreq, 1'b1);
        check("rst_valid", rvalid, 1'b0);
        check("rst_rdata", rdata, '0);
        check("rst_ctrl", ctrl, '0);
        rst = 1'b0;
        check_init("init");

        // Table of single transactions
        for (int i = 0; i < 13; i++) begin
            if (vt[i].is_rd) begin
                bus_rd($sformatf("vec%0d_rd", i), vt[i].a, vt[i].exp);
            end else begin
                bus_wr(vt[i].a, vt[i].d, vt[i].b);
                check($sformatf("vec%0d_ctrl", i), ctrl[vt[i].chk_reg*DW +: DW], vt[i].exp);
            end
        end
        check("ro_write_ctrl_all", ctrl,
              {16'h7777, 16'h6666, 16'h5555, 16'h4444, 16'h3333, 16'hAB34, 16'h0001, 16'hBECC});

        // Four back-to-back reads, returned on consecutive cycles in order
        begin
            logic [AW-1:0] ra [4];
            logic [DW-1:0] re [4];
            ra = '{16'd0, 16'd8, 16'd9, 16'd20};
            re = '{16'hBECC, 16'h0011, 16'h0022, 16'h0000};
            for (int c = 0; c < RL + 5; c++) begin
                if (c >= RL && c < RL + 4) begin
                    check($sformatf("b2b_valid_c%0d", c), rvalid, 1'b1);
                    check($sformatf("b2b_data_c%0d", c), rdata, re[c-RL]);
                end else begin
                    check($sformatf("b2b_idle_c%0d", c), rvalid, 1'b0);
                end
                if (c < 4) begin
                    rd = 1'b1; addr = ra[c];
                end else begin
                    rd = 1'b0;
                end
                step();
            end
        end

        // Write then read same address on the next cycle sees new value
        addr = 16'd5; wdata = 16'h0505; be = 2'b11; wr = 1'b1;
        step();
        wr = 1'b0; rd = 1'b1;
        step();
        rd = 1'b0;
        for (int i = 1; i < RL; i++) step();
        check("wr_rd_valid", rvalid, 1'b1);
        check("wr_rd_data", rdata, 16'h0505);
        step();

        // Read+write in one cycle: write happens, read dropped
        addr = 16'd6; wdata = 16'h0606; be = 2'b11; wr = 1'b1; rd = 1'b1;
        step();
        wr = 1'b0; rd = 1'b0;
        for (int i = 0; i < RL + 1; i++) begin
            check("collide_no_valid", rvalid, 1'b0);
            step();
        end
        bus_rd("collide_wr_done", 16'd6, 16'h0606);

`ifdef AVMM_CSR_SHADOW_EN
        // Commit stall until update_i arrives 5 cycles later
        addr = 16'd1; wdata = 16'h0055; be = 2'b11; wr = 1'b1;
        step();
        wr = 1'b0;
        check("sh_ctrl_before", ctrl[1*DW +: DW], 16'h0001);
        addr = AW'(NRW + NRO); wr = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("sh_stall", waitreq, 1'b1);
            check("sh_ctrl_hold", ctrl[1*DW +: DW], 16'h0001);
            step();
        end
        update = 1'b1;
        #1;
        check("sh_release", waitreq, 1'b0);
        step();
        wr = 1'b0; update = 1'b0;
        check("sh_ctrl_after", ctrl[1*DW +: DW], 16'h0055);
        check("sh_ready", waitreq, 1'b0);
`endif

        // Reset with a read in flight: no readdatavalid, init repeats
        addr = 16'd3; rd = 1'b1;
        step();
        rd = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_valid", rvalid, 1'b0);
        check("midrst_wait", waitreq, 1'b1);
        for (int i = 0; i < RL + 1; i++) begin
            step();
            check("midrst_no_valid", rvalid, 1'b0);
        end
        rst = 1'b0;
        check_init("reinit");
        for (int i = 0; i < RL + 1; i++) begin
            check("post_reinit_no_valid", rvalid, 1'b0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
